// File: rtl/mult_acc_dump_pkg.sv
// Shared types and sizing helpers for the integrate-and-dump stage.
package mult_acc_pkg;

  // Frame FSM: waiting for the first sample of a frame, or summing inside one.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  // Accumulator width that can hold 2^len_w - 1 samples of in_w bits without wrapping.
  function automatic int acc_width(input int in_w, input int len_w);
    return in_w + len_w;
  endfunction

endpackage

// File: rtl/mult_acc_dump_if.sv
// Sample stream in (from the multiplier) and dump stream out.
interface mult_acc_dump_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24
);

  logic                        s_valid;
  logic signed [IN_WIDTH-1:0]  s_data;
  logic                        s_ovf;
  logic                        s_sof;

  logic                        m_valid;
  logic signed [OUT_WIDTH-1:0] m_data;
  logic                        m_ovf;

  // Producer of samples / consumer of dumps.
  modport master (
    output s_valid, s_data, s_ovf, s_sof,
    input  m_valid, m_data, m_ovf
  );

  // The integrate-and-dump stage itself.
  modport slave (
    input  s_valid, s_data, s_ovf, s_sof,
    output m_valid, m_data, m_ovf
  );

endinterface

// File: rtl/mult_acc_dump_round_sat.sv
// Registered round-half-up, arithmetic right shift and saturation of a signed value.
// out_ovf carries in_ovf through and is also raised whenever the value was clipped.
module round_sat #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 24,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_ovf,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf
);

  // One guard bit above the input so adding the rounding constant never wraps,
  // and at least OUT_W bits so the clip limits are representable.
  localparam int W      = ((IN_W + 1) > OUT_W) ? (IN_W + 1) : OUT_W;
  localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;

  localparam logic signed [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] RND_C = (SHIFT > 0) ? (ONE_C <<< RND_SH) : {W{1'b0}};
  localparam logic signed [W-1:0] MAX_C = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_C = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [W-1:0]     ext_s;
  logic signed [W-1:0]     rnd_s;
  logic signed [W-1:0]     clip_s;
  logic                    sat_s;

  // Sign-extend, add half an LSB of the result, shift, then clip to the output range.
  always_comb begin
    ext_s  = {{(W-IN_W){in_data[IN_W-1]}}, in_data};
    rnd_s  = (ext_s + RND_C) >>> SHIFT;
    clip_s = rnd_s;
    sat_s  = 1'b0;
    if (rnd_s > MAX_C) begin
      clip_s = MAX_C;
      sat_s  = 1'b1;
    end else if (rnd_s < MIN_C) begin
      clip_s = MIN_C;
      sat_s  = 1'b1;
    end else begin
      clip_s = rnd_s;
      sat_s  = 1'b0;
    end
  end

  // Output register: valid follows the input every cycle, payload updates only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= clip_s[OUT_W-1:0];
        out_ovf  <= in_ovf | sat_s;
      end
    end
  end

endmodule

// File: rtl/mult_acc_dump.sv
// Integrate-and-dump after the fixed-point multiplier: sums L samples per frame
// at full precision and emits one rounded, saturated result per frame.
module mult_acc_dump
  import mult_acc_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24,
  parameter int LEN_WIDTH = 12,
  parameter int SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 clr,
  mult_acc_dump_if.slave       bus,
  output logic                 err_ovf,
  output logic                 err_sof
);

  localparam int ACC_W = acc_width(IN_WIDTH, LEN_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_C  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] ZERO_C = {LEN_WIDTH{1'b0}};

  acc_state_e              state_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic                    fovf_r;

  logic                    st1_valid_r;
  logic signed [ACC_W-1:0] st1_sum_r;
  logic                    st1_ovf_r;

  logic                    err_sof_r;
  logic                    err_ovf_r;

  logic signed [ACC_W-1:0] data_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [LEN_WIDTH-1:0]    len_eff_s;
  logic [LEN_WIDTH-1:0]    cnt_inc_s;
  logic                    load_s;
  logic                    abort_s;
  logic                    dump_s;
  logic signed [ACC_W-1:0] dump_sum_s;
  logic                    dump_ovf_s;

  // Decide per sample whether it starts a frame, aborts one, or completes one.
  always_comb begin
    data_ext_s = {{LEN_WIDTH{bus.s_data[IN_WIDTH-1]}}, bus.s_data};
    sum_s      = acc_r + data_ext_s;
    len_eff_s  = (len == ZERO_C) ? ONE_C : len;
    cnt_inc_s  = cnt_r + ONE_C;
    load_s     = 1'b0;
    abort_s    = 1'b0;
    dump_s     = 1'b0;
    dump_sum_s = acc_r;
    dump_ovf_s = fovf_r;
    if (bus.s_valid) begin
      if ((state_r == IDLE) || bus.s_sof) begin
        // A start-of-frame inside a frame restarts it from this sample.
        load_s     = 1'b1;
        abort_s    = (state_r == ACC);
        dump_s     = (len_eff_s == ONE_C);
        dump_sum_s = data_ext_s;
        dump_ovf_s = bus.s_ovf;
      end else begin
        dump_s     = (cnt_inc_s == len_r);
        dump_sum_s = sum_s;
        dump_ovf_s = fovf_r | bus.s_ovf;
      end
    end else begin
      load_s = 1'b0;
      dump_s = 1'b0;
    end
  end

  // Frame FSM with counter and accumulator; idle cycles hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= ZERO_C;
      len_r   <= ZERO_C;
      fovf_r  <= 1'b0;
    end else if (bus.s_valid) begin
      if (dump_s) begin
        state_r <= IDLE;
        acc_r   <= {ACC_W{1'b0}};
        cnt_r   <= ZERO_C;
        fovf_r  <= 1'b0;
        if (load_s) begin
          len_r <= len_eff_s;
        end
      end else if (load_s) begin
        state_r <= ACC;
        acc_r   <= data_ext_s;
        cnt_r   <= ONE_C;
        len_r   <= len_eff_s;
        fovf_r  <= bus.s_ovf;
      end else begin
        state_r <= ACC;
        acc_r   <= sum_s;
        cnt_r   <= cnt_inc_s;
        fovf_r  <= fovf_r | bus.s_ovf;
      end
    end
  end

  // Stage 1 of the dump pipeline: capture the completed sum and its overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_valid_r <= 1'b0;
      st1_sum_r   <= {ACC_W{1'b0}};
      st1_ovf_r   <= 1'b0;
    end else begin
      st1_valid_r <= dump_s;
      if (dump_s) begin
        st1_sum_r <= dump_sum_s;
        st1_ovf_r <= dump_ovf_s;
      end
    end
  end

  // Abort pulse one cycle after the sample that restarted the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sof_r <= 1'b0;
    end else begin
      err_sof_r <= abort_s;
    end
  end

  // Sticky overflow; an overflowing dump wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_r <= 1'b0;
    end else if (bus.m_valid && bus.m_ovf) begin
      err_ovf_r <= 1'b1;
    end else if (clr) begin
      err_ovf_r <= 1'b0;
    end
  end

  assign err_sof = err_sof_r;
  assign err_ovf = err_ovf_r;

  // Stage 2 of the dump pipeline drives the output stream directly.
  round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (st1_valid_r),
    .in_data   (st1_sum_r),
    .in_ovf    (st1_ovf_r),
    .out_valid (bus.m_valid),
    .out_data  (bus.m_data),
    .out_ovf   (bus.m_ovf)
  );

endmodule

// File: tb/tb_mult_acc_dump.sv
// Directed bench: three instances share one stimulus stream
//   a: OUT_WIDTH=24 SHIFT=0, b: OUT_WIDTH=16 SHIFT=0, c: OUT_WIDTH=24 SHIFT=2.
module tb_mult_acc_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] len;
  logic        clr;
  logic        err_ovf_a, err_ovf_b, err_ovf_c;
  logic        err_sof_a, err_sof_b, err_sof_c;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mult_acc_dump_if #(.IN_WIDTH(16), .OUT_WIDTH(24)) if_a ();
  mult_acc_dump_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) if_b ();
  mult_acc_dump_if #(.IN_WIDTH(16), .OUT_WIDTH(24)) if_c ();

  mult_acc_dump #(.IN_WIDTH(16), .OUT_WIDTH(24), .LEN_WIDTH(12), .SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .len(len), .clr(clr), .bus(if_a.slave),
    .err_ovf(err_ovf_a), .err_sof(err_sof_a));
  mult_acc_dump #(.IN_WIDTH(16), .OUT_WIDTH(16), .LEN_WIDTH(12), .SHIFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .len(len), .clr(clr), .bus(if_b.slave),
    .err_ovf(err_ovf_b), .err_sof(err_sof_b));
  mult_acc_dump #(.IN_WIDTH(16), .OUT_WIDTH(24), .LEN_WIDTH(12), .SHIFT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .len(len), .clr(clr), .bus(if_c.slave),
    .err_ovf(err_ovf_c), .err_sof(err_sof_c));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [15:0] d,
                       input logic o, input logic sf);
    if_a.s_valid = v; if_a.s_data = d; if_a.s_ovf = o; if_a.s_sof = sf;
    if_b.s_valid = v; if_b.s_data = d; if_b.s_ovf = o; if_b.s_sof = sf;
    if_c.s_valid = v; if_c.s_data = d; if_c.s_ovf = o; if_c.s_sof = sf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample accepted on the next edge; returns 1 time unit after it.
  task automatic send(input logic signed [15:0] d, input logic o, input logic sf);
    drive(1'b1, d, o, sf);
    step();
    drive(1'b0, 16'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    len   = 12'd0;
    clr   = 1'b0;
    drive(1'b0, 16'sd0, 1'b0, 1'b0);
    repeat (3) step();

    // Reset state
    chk("rst_m_valid", if_a.m_valid, 0);
    chk("rst_m_data", if_a.m_data, 0);
    chk("rst_m_ovf", if_a.m_ovf, 0);
    chk("rst_err_ovf", err_ovf_a, 0);
    chk("rst_err_sof", err_sof_a, 0);
    chk("rst_b_m_valid", if_b.m_valid, 0);
    rst_n = 1'b1;
    step();

    // len=4, 1+2+3+4 continuous, result two cycles after the 4th sample
    len = 12'd4;
    send(16'sd1, 1'b0, 1'b0);
    send(16'sd2, 1'b0, 1'b0);
    send(16'sd3, 1'b0, 1'b0);
    send(16'sd4, 1'b0, 1'b0);
    chk("t1_not_early", if_a.m_valid, 0);
    step();
    chk("t1_valid", if_a.m_valid, 1);
    chk("t1_data", if_a.m_data, 10);
    chk("t1_ovf", if_a.m_ovf, 0);
    chk("t1_b_data", if_b.m_data, 10);
    chk("t1_c_data", if_c.m_data, 3);
    step();
    chk("t1_pulse_end", if_a.m_valid, 0);

    // len=0 then len=1, back-to-back single-sample frames
    len = 12'd0;
    send(16'sd5, 1'b0, 1'b0);
    len = 12'd1;
    send(-16'sd7, 1'b0, 1'b0);
    chk("t2_valid0", if_a.m_valid, 1);
    chk("t2_data0", if_a.m_data, 5);
    chk("t2_c_data0", if_c.m_data, 1);
    step();
    chk("t2_valid1", if_a.m_valid, 1);
    chk("t2_data1", if_a.m_data, -7);
    chk("t2_c_data1", if_c.m_data, -2);
    step();
    chk("t2_pulse_end", if_a.m_valid, 0);

    // Saturation on the 16-bit output instance
    len = 12'd4;
    repeat (4) send(16'sd32767, 1'b0, 1'b0);
    step();
    chk("t3_b_valid", if_b.m_valid, 1);
    chk("t3_b_data", if_b.m_data, 32767);
    chk("t3_b_ovf", if_b.m_ovf, 1);
    chk("t3_a_data", if_a.m_data, 131068);
    chk("t3_a_ovf", if_a.m_ovf, 0);
    chk("t3_c_data", if_c.m_data, 32767);
    chk("t3_c_ovf", if_c.m_ovf, 0);
    step();
    chk("t3_b_err_set", err_ovf_b, 1);
    chk("t3_a_err_clear", err_ovf_a, 0);
    step();
    step();
    chk("t3_b_err_sticky", err_ovf_b, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_b_err_clr", err_ovf_b, 0);

    // Multiplier overflow on 2nd sample only; set beats a coincident clear
    len = 12'd3;
    send(16'sd1, 1'b0, 1'b0);
    send(16'sd1, 1'b1, 1'b0);
    send(16'sd1, 1'b0, 1'b0);
    step();
    chk("t4_valid0", if_a.m_valid, 1);
    chk("t4_data0", if_a.m_data, 3);
    chk("t4_ovf0", if_a.m_ovf, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_set_wins", err_ovf_a, 1);
    // Next frame with idle gaps between samples
    send(16'sd1, 1'b0, 1'b0);
    step();
    step();
    send(16'sd1, 1'b0, 1'b0);
    step();
    chk("t4_gap_no_dump", if_a.m_valid, 0);
    send(16'sd1, 1'b0, 1'b0);
    step();
    chk("t4_valid1", if_a.m_valid, 1);
    chk("t4_data1", if_a.m_data, 3);
    chk("t4_ovf1", if_a.m_ovf, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_err_clr", err_ovf_a, 0);

    // Start-of-frame aborts a partial frame
    len = 12'd4;
    send(16'sd5, 1'b0, 1'b0);
    send(16'sd6, 1'b0, 1'b0);
    send(16'sd9, 1'b0, 1'b1);
    chk("t5_err_sof", err_sof_a, 1);
    chk("t5_no_dump", if_a.m_valid, 0);
    send(16'sd1, 1'b0, 1'b0);
    chk("t5_err_sof_pulse", err_sof_a, 0);
    chk("t5_no_dump2", if_a.m_valid, 0);
    send(16'sd1, 1'b0, 1'b0);
    send(16'sd1, 1'b0, 1'b0);
    step();
    chk("t5_valid", if_a.m_valid, 1);
    chk("t5_data", if_a.m_data, 12);
    chk("t5_c_data", if_c.m_data, 3);

    // SHIFT=2 rounding, positive and negative
    len = 12'd2;
    send(16'sd3, 1'b0, 1'b0);
    send(16'sd2, 1'b0, 1'b0);
    step();
    chk("t6_c_pos", if_c.m_data, 1);
    chk("t6_a_pos", if_a.m_data, 5);
    send(-16'sd3, 1'b0, 1'b0);
    send(-16'sd2, 1'b0, 1'b0);
    step();
    chk("t6_c_neg", if_c.m_data, -1);
    chk("t6_a_neg", if_a.m_data, -5);

    // len change mid-frame is ignored
    len = 12'd2;
    send(16'sd1, 1'b0, 1'b0);
    len = 12'd1;
    send(16'sd2, 1'b0, 1'b0);
    chk("t7_no_early", if_a.m_valid, 0);
    step();
    chk("t7_valid", if_a.m_valid, 1);
    chk("t7_data", if_a.m_data, 3);

    // Reset mid-frame loses the partial sum
    len = 12'd4;
    send(16'sd1, 1'b0, 1'b0);
    send(16'sd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_data", if_a.m_data, 0);
    chk("t8_rst_valid", if_a.m_valid, 0);
    step();
    rst_n = 1'b1;
    len = 12'd2;
    send(16'sd4, 1'b0, 1'b0);
    send(16'sd5, 1'b0, 1'b0);
    step();
    chk("t8_fresh_valid", if_a.m_valid, 1);
    chk("t8_fresh_data", if_a.m_data, 9);

    // Reset with a dump in flight drops it
    len = 12'd1;
    send(16'sd7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t9_rst_valid", if_a.m_valid, 0);
    chk("t9_rst_data", if_a.m_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t9_no_spurious0", if_a.m_valid, 0);
    step();
    chk("t9_no_spurious1", if_a.m_valid, 0);
    chk("t9_err_ovf", err_ovf_a, 0);
    chk("t9_err_sof", err_sof_a, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
